qam_carrier_scheduler: RTL
==========================

# qam_carrier_scheduler

Sequences the shared sine/cosine carrier LUT for the QAM modulator. Accepts 4-bit 16-QAM symbols from the symbol source over a valid/ready handshake into a 4-entry FIFO. Drives the LUT enable and reset so that each symbol spans exactly SPS carrier samples. Presents Gray-decoded I/Q amplitude levels that are cycle-aligned with the LUT output register, for the downstream multiply/sum stage.

## Interface
- SPS, 1020: carrier samples per symbol; 1020 is one full LUT carrier period. Legal range 2..4095.
- DIV, 1: clock cycles per carrier sample; lut_en pulses once every DIV cycles. Legal range 1..255.
- FIFO_DEPTH, 4: symbol FIFO entries; fixed power of two.
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset (rst=0 resets on the next clk edge).
- tx_en  in  1  transmit enable; level-sensitive.
- sym_data  in  4  symbol: [3:2] selects I, [1:0] selects Q.
- sym_valid  in  1  source has a symbol on sym_data.
- sym_ready  out  1  FIFO can accept; equals "FIFO not full", combinational from the registered count.
- lut_rst  out  1  active-high hold/reset to the carrier LUT.
- lut_en  out  1  carrier LUT sample enable.
- i_level  out  3  signed two's-complement I amplitude.
- q_level  out  3  signed two's-complement Q amplitude.
- sym_strobe  out  1  one-cycle pulse in the first cycle a new symbol's levels are valid.
- busy  out  1  high when state is not IDLE.
- underrun  out  1  sticky flag: FIFO was empty at a symbol boundary while tx_en=1.

## Operation
- FIFO push: on any cycle with sym_valid && sym_ready. No push occurs when the FIFO is full, regardless of pops.
- FIFO pop: only at a symbol start (see RUN). A push and a pop in the same cycle leave the count unchanged.
- Level decode (Gray), applied to I and Q independently:
  - 00 -> -3 (3'b101)
  - 01 -> -1 (3'b111)
  - 11 -> +1 (3'b001)
  - 10 -> +3 (3'b011)
- State machine:
  - **IDLE**: lut_rst=1, lut_en=0, i_level=q_level=0.
    - Go to PRIME when tx_en=1 and the FIFO is non-empty.
  - **PRIME**: exactly one cycle, lut_rst=0, lut_en=0.
    - Clears underrun.
    - Loads div_cnt=0 and sample_cnt=0.
    - Go to RUN.
  - **RUN**: lut_rst=0. A "tick" is any cycle with div_cnt==0; div_cnt counts 0..DIV-1 and wraps. lut_en=1 on ticks only.
    - Tick with sample_cnt==0: pop the FIFO head into the level registers.
    - Every tick: sample_cnt increments and wraps at SPS-1 -> 0.
    - Tick with sample_cnt==SPS-1, tx_en=1, FIFO non-empty: stay in RUN; the next tick starts a new symbol.
    - Tick with sample_cnt==SPS-1, tx_en=0: go to IDLE (graceful stop; no underrun).
    - Tick with sample_cnt==SPS-1, tx_en=1, FIFO empty: set underrun, go to IDLE.
- Dropping tx_en mid-symbol never truncates the symbol; the current symbol always completes all SPS samples.
- Queued FIFO entries survive IDLE. They are cleared only by reset.
- Reset (rst=0 at an edge), at any time including mid-symbol:
  - state=IDLE, FIFO emptied, all counters 0.
  - lut_rst=1, lut_en=0, i_level=q_level=0, sym_strobe=0, busy=0, underrun=0.
  - sym_ready=1 from the first cycle after reset.

## Timing
- Level alignment: the pop on the sample-0 tick updates i_level/q_level at the same edge at which the LUT registers sample 0. New levels are therefore visible one cycle after that lut_en cycle, concurrent with the LUT's new output.
- sym_strobe is high for exactly that same one cycle.
- Latency from tx_en rising (FIFO non-empty, in IDLE):
  - Cycle 0: IDLE detects the condition.
  - Cycle 1: PRIME.
  - Cycle 2: first lut_en.
  - Cycle 3: first levels and sym_strobe.
- Symbol period in RUN: SPS*DIV cycles with no gap between back-to-back symbols.
- IDLE exit after the last tick:
  - The next cycle is IDLE: lut_rst=1 and levels = 0.
  - That cycle is also the cycle in which the LUT shows the final sample, so levels return to 0 as the last carrier sample appears.
- Counter widths:
  - sample_cnt: 12 bits.
  - div_cnt: 8 bits.
  - FIFO count: 3 bits, range 0..4.

## Test plan
- Reset and idle (SPS=4, DIV=1): hold rst=0 for 3 cycles, then release.
  - Required: lut_rst=1, lut_en=0, levels 0, sym_ready=1, busy=0, underrun=0.
- Back-to-back stream (SPS=4, DIV=1): push 0x2 then 0xD, tx_en=1.
  - lut_en high continuously for 8 cycles.
  - Levels (-3,+3) for 4 cycles, then (+1,-1) for 4 cycles; sym_strobe pulses 4 cycles apart.
  - Then IDLE with underrun=1.
- Divider (SPS=4, DIV=3): push one symbol 0xF.
  - lut_en pulses every 3rd cycle, 4 pulses total.
  - Levels (+1,+1) held for 12 cycles.
- FIFO full/backpressure: with tx_en=0, push 5 symbols holding sym_valid=1.
  - sym_ready drops after the 4th accept; the 5th is held until the first pop after tx_en rises.
  - All 5 symbols appear in order.
- Graceful stop (SPS=4, DIV=1): with 3 symbols queued, drop tx_en at the 2nd sample of symbol 1.
  - Symbol 1 completes all 4 samples, then IDLE, underrun=0.
  - 2 entries remain; raising tx_en resumes with symbol 2.
- Reset mid-symbol: rst=0 at the 2nd sample.
  - Next edge: all reset values, FIFO empty, sym_ready=1.

Source files
------------

// File: rtl/qam_carrier_scheduler.sv
// Carrier LUT sequencer for the QAM modulator: buffers 16-QAM symbols, paces the
// sine/cosine LUT so each symbol spans SPS samples, and emits Gray-decoded I/Q levels.
module qam_carrier_scheduler #(
  parameter int SPS        = 1020,
  parameter int DIV        = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic [3:0] sym_data,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       lut_rst,
  output logic       lut_en,
  output logic [2:0] i_level,
  output logic [2:0] q_level,
  output logic       sym_strobe,
  output logic       busy,
  output logic       underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [11:0] SPS_LAST  = 12'(SPS - 1);
  localparam logic [7:0]  DIV_LAST  = 8'(DIV - 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic [7:0]      div_cnt_reg;
  logic [11:0]     sample_cnt_reg;
  logic [2:0]      i_level_reg, q_level_reg;
  logic            strobe_reg, underrun_reg;
  logic            push, pop, tick, last_sample, fifo_empty, set_underrun;

  function automatic logic [2:0] gray_level(input logic [1:0] g);
    case (g)
      2'b00:   return 3'b101;
      2'b01:   return 3'b111;
      2'b11:   return 3'b001;
      default: return 3'b011;
    endcase
  endfunction

  assign fifo_empty  = (count_reg == '0);
  assign sym_ready   = (count_reg != FULL_CNT);
  assign push        = sym_valid && sym_ready;
  assign tick        = (state_reg == RUN) && (div_cnt_reg == 8'd0);
  assign last_sample = (sample_cnt_reg == SPS_LAST);
  assign pop         = tick && (sample_cnt_reg == 12'd0);

  always_comb begin
    state_next   = state_reg;
    set_underrun = 1'b0;
    case (state_reg)
      IDLE:  if (tx_en && !fifo_empty) state_next = PRIME;
      PRIME: state_next = RUN;
      RUN: begin
        // Boundary decision is taken on the final tick, so a symbol is never cut short.
        if (tick && last_sample) begin
          if (!tx_en) begin
            state_next = IDLE;
          end else if (fifo_empty) begin
            state_next   = IDLE;
            set_underrun = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Storage array kept free of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= sym_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      div_cnt_reg    <= '0;
      sample_cnt_reg <= '0;
      i_level_reg    <= '0;
      q_level_reg    <= '0;
      strobe_reg     <= 1'b0;
      underrun_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase

      if (state_reg == RUN)
        div_cnt_reg <= (div_cnt_reg == DIV_LAST) ? 8'd0 : div_cnt_reg + 8'd1;
      else
        div_cnt_reg <= 8'd0;

      if (tick)
        sample_cnt_reg <= last_sample ? 12'd0 : sample_cnt_reg + 12'd1;
      else if (state_reg != RUN)
        sample_cnt_reg <= 12'd0;

      // Levels update on the same edge the LUT captures sample 0.
      if (state_next == IDLE) begin
        i_level_reg <= 3'b000;
        q_level_reg <= 3'b000;
      end else if (pop) begin
        i_level_reg <= gray_level(fifo_mem[rd_ptr_reg][3:2]);
        q_level_reg <= gray_level(fifo_mem[rd_ptr_reg][1:0]);
      end

      strobe_reg <= pop;

      if (state_reg == PRIME)
        underrun_reg <= 1'b0;
      else if (set_underrun)
        underrun_reg <= 1'b1;
    end
  end

  assign lut_rst    = (state_reg == IDLE);
  assign lut_en     = tick;
  assign i_level    = i_level_reg;
  assign q_level    = q_level_reg;
  assign sym_strobe = strobe_reg;
  assign busy       = (state_reg != IDLE);
  assign underrun   = underrun_reg;

endmodule
